// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
// The optional parity bit is controlled by the UART_TX_PARITY_EN macro.
package uart_pkg;

  // Serial frame constants
  localparam int   DATA_W    = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Transmit FSM states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Even parity over one data byte: the XOR of all its bits
  function automatic logic even_parity(input logic [DATA_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO that buffers bytes waiting to be serialised.
// The pointers carry one extra bit so that full and empty can be told apart.
// DEPTH must be a power of two and at least 2.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Status comes from registered pointers only, so ready never depends on this cycle's pop
  always_comb begin
    empty_o = (wr_ptr_q == rd_ptr_q);
    full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    data_o  = mem_q[rd_ptr_q[AW-1:0]];
  end

  // A push into a full FIFO is refused even if a pop frees a slot on the same cycle
  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = data_i;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Pointer registers; reset empties the FIFO and discards any queued bytes
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset because the pointers define which entries are live
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO in front of a start/data/[parity]/stop serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit after data bit 7.
module uart_tx
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 tx_en_i,
  input  logic [DIV_WIDTH-1:0] cfg_div_i,
  input  logic [DATA_W-1:0]    data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 char_done_o
);

  tx_state_e            state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DATA_W-1:0]    shift_q, shift_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic                 tx_q, tx_d;
  logic                 char_done_q, char_done_d;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_pop;
  logic              start_ok;
  logic              load_frame;
  logic              bit_end;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (valid_i),
    .data_i  (data_i),
    .pop_i   (fifo_pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Handshake and status outputs
  always_comb begin
    ready_o     = !fifo_full;
    busy_o      = (state_q != ST_IDLE) || !fifo_empty;
    tx_o        = tx_q;
    char_done_o = char_done_q;
  end

  // Next-state logic: bit timing, frame sequencing and back-to-back frame launch
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    char_done_d = 1'b0;
    fifo_pop    = 1'b0;
    load_frame  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif
    start_ok = tx_en_i && !fifo_empty;
    bit_end  = (cnt_q == '0);

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          load_frame = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          cnt_d     = div_q;
          bit_idx_d = '0;
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_d = div_q;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          cnt_d   = div_q;
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          char_done_d = 1'b1;
          if (start_ok) begin
            load_frame = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (load_frame) begin
      state_d   = ST_START;
      fifo_pop  = 1'b1;
      div_d     = cfg_div_i;
      cnt_d     = cfg_div_i;
      shift_d   = fifo_data;
      bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
      parity_d  = even_parity(fifo_data);
`endif
    end
  end

  // Line level for the bit the FSM is currently timing; registered one cycle later
  always_comb begin
    tx_d = STOP_BIT;
    case (state_q)
      ST_START:  tx_d = START_BIT;
      ST_DATA:   tx_d = shift_q[bit_idx_q];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_q;
`endif
      default:   tx_d = STOP_BIT;
    endcase
  end

  // State, timing and output registers; reset aborts any frame and idles the line
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      div_q       <= '0;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      tx_q        <= STOP_BIT;
      char_done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      tx_q        <= tx_d;
      char_done_q <= char_done_d;
`ifdef UART_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

endmodule
